// File: rtl/slib_rx_sequencer.sv
// UART receive-frame controller: finds the start edge, samples each bit mid-cell
// on the 16x baud enable and reports one character with parity/framing/break status.
module slib_rx_sequencer (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RXCLK,
  input  logic       CLEAR,
  input  logic       RXD,
  input  logic [1:0] WLS,
  input  logic       PEN,
  input  logic       EPS,
  input  logic       SP,
  output logic [7:0] DOUT,
  output logic       PE,
  output logic       FE,
  output logic       BI,
  output logic       RXFINISHED,
  output logic       BUSY
);

  typedef enum logic [2:0] {IDLE, START, DATA, PAR, STOP} state_t;

  state_t     state;
  logic       rxd_dly;
  logic [3:0] tick_cnt;
  logic [7:0] shift;
  logic [2:0] bit_cnt;
  logic       par_bit;
  logic [1:0] cfg_wls;
  logic       cfg_pen;
  logic       cfg_eps;
  logic       cfg_sp;

  logic fall;
  logic sample;
  logic exp_par;

  assign fall    = rxd_dly & ~RXD;
  assign sample  = RXCLK & (tick_cnt == 4'd7);
  // Upper shift bits are cleared at frame start, so a full 8-bit XOR is the data parity.
  assign exp_par = cfg_sp ? ~cfg_eps : (cfg_eps ? ^shift : ~^shift);

  always_ff @(posedge CLK) begin
    if (!RST || CLEAR) begin
      state      <= IDLE;
      rxd_dly    <= 1'b1;
      tick_cnt   <= 4'd0;
      shift      <= 8'd0;
      bit_cnt    <= 3'd0;
      par_bit    <= 1'b0;
      cfg_wls    <= 2'd0;
      cfg_pen    <= 1'b0;
      cfg_eps    <= 1'b0;
      cfg_sp     <= 1'b0;
      DOUT       <= 8'd0;
      PE         <= 1'b0;
      FE         <= 1'b0;
      BI         <= 1'b0;
      RXFINISHED <= 1'b0;
      BUSY       <= 1'b0;
    end else begin
      rxd_dly    <= RXD;
      RXFINISHED <= 1'b0;
      if (RXCLK) tick_cnt <= tick_cnt + 4'd1;

      case (state)
        IDLE: begin
          if (fall) begin
            tick_cnt <= 4'd0;
            cfg_wls  <= WLS;
            cfg_pen  <= PEN;
            cfg_eps  <= EPS;
            cfg_sp   <= SP;
            shift    <= 8'd0;
            bit_cnt  <= 3'd0;
            state    <= START;
            BUSY     <= 1'b1;
          end
        end
        START: begin
          if (sample) begin
            if (RXD) begin
              state <= IDLE;
              BUSY  <= 1'b0;
            end else begin
              state <= DATA;
            end
          end
        end
        DATA: begin
          if (sample) begin
            shift[bit_cnt] <= RXD;
            bit_cnt        <= bit_cnt + 3'd1;
            if (bit_cnt == 3'd4 + {1'b0, cfg_wls}) state <= cfg_pen ? PAR : STOP;
          end
        end
        PAR: begin
          if (sample) begin
            par_bit <= RXD;
            state   <= STOP;
          end
        end
        STOP: begin
          if (sample) begin
            state      <= IDLE;
            BUSY       <= 1'b0;
            RXFINISHED <= 1'b1;
            DOUT       <= shift;
            FE         <= ~RXD;
            PE         <= cfg_pen & (par_bit != exp_par);
            BI         <= (shift == 8'd0) & ~(cfg_pen & par_bit) & ~RXD;
          end
        end
        default: begin
          state <= IDLE;
          BUSY  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_slib_rx_sequencer.sv
// Bench for slib_rx_sequencer: frames are built bit by bit, expected results and
// pulse timing are derived from the frame contents and the tick schedule.
module tb_slib_rx_sequencer;

  logic       CLK = 1'b0;
  logic       RST = 1'b0;
  logic       RXCLK = 1'b0;
  logic       CLEAR = 1'b0;
  logic       RXD = 1'b1;
  logic [1:0] WLS = 2'd0;
  logic       PEN = 1'b0;
  logic       EPS = 1'b0;
  logic       SP = 1'b0;
  logic [7:0] DOUT;
  logic       PE;
  logic       FE;
  logic       BI;
  logic       RXFINISHED;
  logic       BUSY;

  slib_rx_sequencer dut (
    .CLK(CLK), .RST(RST), .RXCLK(RXCLK), .CLEAR(CLEAR), .RXD(RXD),
    .WLS(WLS), .PEN(PEN), .EPS(EPS), .SP(SP),
    .DOUT(DOUT), .PE(PE), .FE(FE), .BI(BI),
    .RXFINISHED(RXFINISHED), .BUSY(BUSY)
  );

  always #5 CLK = ~CLK;

  int pos_cnt = 0;
  always @(posedge CLK) pos_cnt <= pos_cnt + 1;

  int checks = 0;
  int errors = 0;

  typedef struct {
    int         at;
    bit         fin;
    logic [7:0] dout;
    logic       pe;
    logic       fe;
    logic       bi;
  } ev_t;

  ev_t        evq[$];
  int         busy_from = 0;
  int         busy_to = 0;
  logic [7:0] exp_dout = 8'd0;
  logic       exp_pe = 1'b0;
  logic       exp_fe = 1'b0;
  logic       exp_bi = 1'b0;
  logic       exp_fin = 1'b0;
  int         fin_count = 0;
  int         last_fin = -1;
  int         cur = 0;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s cycle %0d: got %0h expected %0h", name, pos_cnt, got, want);
    end
  endtask

  // Per-cycle comparison against the expected event stream
  always @(negedge CLK) begin
    ev_t ev;
    if (pos_cnt >= 1) begin
      exp_fin = 1'b0;
      if (evq.size() > 0 && evq[0].at == pos_cnt) begin
        ev       = evq.pop_front();
        exp_fin  = ev.fin;
        exp_dout = ev.dout;
        exp_pe   = ev.pe;
        exp_fe   = ev.fe;
        exp_bi   = ev.bi;
      end
      if (RXFINISHED === 1'b1) begin
        fin_count++;
        last_fin = pos_cnt;
      end
      chk("rxfinished", RXFINISHED, exp_fin);
      chk("busy", BUSY, (pos_cnt >= busy_from && pos_cnt < busy_to));
      chk("dout", DOUT, exp_dout);
      chk("pe", PE, exp_pe);
      chk("fe", FE, exp_fe);
      chk("bi", BI, exp_bi);
    end
  end

  // Sets inputs for the next rising edge; cur holds that edge's index.
  task automatic drive(input logic rxd, input logic rxclk);
    @(posedge CLK);
    #1;
    RXD   = rxd;
    RXCLK = rxclk;
    RST   = 1'b1;
    CLEAR = 1'b0;
    WLS   = 2'($urandom_range(0, 3));
    PEN   = 1'($urandom_range(0, 1));
    EPS   = 1'($urandom_range(0, 1));
    SP    = 1'($urandom_range(0, 1));
    cur   = pos_cnt + 1;
    if (pos_cnt > 95000) begin
      $display("FAIL watchdog cycle %0d: got running expected finished", pos_cnt);
      $fatal(1);
    end
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) drive(1'b1, 1'($urandom_range(0, 1)));
  endtask

  // abort_mode: 0 none, 1 RST during DATA, 2 CLEAR during DATA
  task automatic send_frame(input logic [1:0] wls, input logic pen, input logic eps,
                            input logic sp, input logic [7:0] data, input logic par,
                            input logic stop, input int p, input int phase,
                            input int extra_low, input int abort_mode, output int e);
    int         nd, nb, first, s_rel, abort_at;
    logic       lv [0:11];
    logic [7:0] d, m;
    logic       x, ep;
    ev_t        ev;
    nd    = 5 + int'(wls);
    nb    = nd + int'(pen) + 2;
    lv[0] = 1'b0;
    for (int i = 0; i < nd; i++) lv[1 + i] = data[i];
    if (pen) lv[1 + nd] = par;
    lv[nb - 1] = stop;
    first    = (phase > 0) ? phase : p;
    s_rel    = first + (16 * (nb - 1) + 7) * p;
    abort_at = (abort_mode != 0) ? first + 35 * p : -1;
    m  = 8'hFF >> (8 - nd);
    d  = data & m;
    x  = ^d;
    ep = sp ? ~eps : (eps ? x : ~x);
    ev.fin  = 1'b1;
    ev.dout = d;
    ev.pe   = pen & (par != ep);
    ev.fe   = ~stop;
    ev.bi   = (d == 8'd0) && (!pen || par == 1'b0) && (stop == 1'b0);
    e = 0;
    for (int c = 0; c < nb * 16 * p; c++) begin
      drive(lv[c / (16 * p)], (c % p) == phase);
      if (c == 0) begin
        e         = cur;
        WLS       = wls;
        PEN       = pen;
        EPS       = eps;
        SP        = sp;
        busy_from = e;
        if (abort_at > 0) begin
          busy_to = e + abort_at;
          ev.at   = e + abort_at;
          ev.fin  = 1'b0;
          ev.dout = 8'd0;
          ev.pe   = 1'b0;
          ev.fe   = 1'b0;
          ev.bi   = 1'b0;
        end else begin
          busy_to = e + s_rel;
          ev.at   = e + s_rel;
        end
        evq.push_back(ev);
      end
      if (c == abort_at) begin
        RXD = 1'b1;
        if (abort_mode == 1) RST = 1'b0;
        else CLEAR = 1'b1;
        break;
      end
    end
    if (abort_at < 0)
      for (int c = 0; c < extra_low * 16 * p; c++) drive(1'b0, (c % p) == phase);
  endtask

  task automatic false_start(input int p, input int phase, input int low_ticks);
    int first, s_rel;
    first = (phase > 0) ? phase : p;
    s_rel = first + 7 * p;
    for (int c = 0; c < s_rel + 4 * p; c++) begin
      drive((c <= first + (low_ticks - 1) * p) ? 1'b0 : 1'b1, (c % p) == phase);
      if (c == 0) begin
        busy_from = cur;
        busy_to   = cur + s_rel;
      end
    end
  endtask

  initial begin
    int e, fc, p, ph, kind;
    repeat (3) @(posedge CLK);
    #1;
    chk("reset_dout", DOUT, 8'h00);
    chk("reset_busy", BUSY, 1'b0);
    chk("reset_fin", RXFINISHED, 1'b0);
    idle(5);

    // 8N1 0xA5, tick every 4 clocks
    fc = fin_count;
    send_frame(2'b11, 1'b0, 1'b0, 1'b0, 8'hA5, 1'b0, 1'b1, 4, 0, 0, 0, e);
    idle(10);
    chk("a5_pulses", fin_count - fc, 1);
    chk("a5_dout", DOUT, 8'hA5);
    chk("a5_flags", {PE, FE, BI}, 3'b000);
    chk("a5_busy", BUSY, 1'b0);
    chk("a5_latency", last_fin - e, 608);

    // 7E1 0x35 with wrong parity bit
    send_frame(2'b10, 1'b1, 1'b1, 1'b0, 8'h35, 1'b1, 1'b1, 3, 1, 0, 0, e);
    idle(10);
    chk("7e1_dout", DOUT, 8'h35);
    chk("7e1_pe", PE, 1'b1);
    chk("7e1_fe", FE, 1'b0);

    // false start
    fc = fin_count;
    false_start(4, 2, 3);
    idle(20);
    chk("false_pulses", fin_count - fc, 0);
    chk("false_busy", BUSY, 1'b0);

    // break: 30 bit times low, 5N1
    fc = fin_count;
    send_frame(2'b00, 1'b0, 1'b0, 1'b0, 8'h00, 1'b0, 1'b0, 4, 0, 23, 0, e);
    idle(60);
    chk("brk_pulses", fin_count - fc, 1);
    chk("brk_dout", DOUT, 8'h00);
    chk("brk_fe", FE, 1'b1);
    chk("brk_bi", BI, 1'b1);

    // stick parity, expected parity bit 0
    send_frame(2'b11, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b0, 1'b1, 2, 1, 0, 0, e);
    idle(8);
    chk("stick0_pe", PE, 1'b0);
    send_frame(2'b11, 1'b1, 1'b1, 1'b1, 8'hFF, 1'b1, 1'b1, 2, 0, 0, 0, e);
    idle(8);
    chk("stick1_pe", PE, 1'b1);
    chk("stick1_dout", DOUT, 8'hFF);

    // reset then clear during DATA, each followed by a clean 0x3C
    fc = fin_count;
    send_frame(2'b11, 1'b0, 1'b0, 1'b0, 8'h5A, 1'b0, 1'b1, 4, 0, 0, 1, e);
    idle(1);
    chk("rst_busy", BUSY, 1'b0);
    chk("rst_out", {DOUT, PE, FE, BI}, 11'd0);
    chk("rst_pulses", fin_count - fc, 0);
    idle(6);
    send_frame(2'b11, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 3, 2, 0, 0, e);
    idle(6);
    chk("post_rst_dout", DOUT, 8'h3C);
    fc = fin_count;
    send_frame(2'b11, 1'b0, 1'b0, 1'b0, 8'hC3, 1'b0, 1'b1, 4, 3, 0, 2, e);
    idle(1);
    chk("clr_busy", BUSY, 1'b0);
    chk("clr_out", {DOUT, PE, FE, BI}, 11'd0);
    chk("clr_pulses", fin_count - fc, 0);
    idle(6);
    send_frame(2'b11, 1'b0, 1'b0, 1'b0, 8'h3C, 1'b0, 1'b1, 2, 0, 0, 0, e);
    idle(6);
    chk("post_clr_dout", DOUT, 8'h3C);

    // randomized frames
    for (int n = 0; n < 30; n++) begin
      p    = $urandom_range(2, 4);
      ph   = $urandom_range(0, p - 1);
      kind = $urandom_range(0, 9);
      if (kind == 0) begin
        false_start(p, ph, $urandom_range(1, 6));
      end else begin
        send_frame(2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                   8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)),
                   ($urandom_range(0, 9) != 0), p, ph, 0,
                   (kind == 1) ? int'($urandom_range(1, 2)) : 0, e);
      end
      idle($urandom_range(2, 20));
    end

    idle(20);
    chk("pending_events", evq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/slib_rx_sequencer.md
# slib_rx_sequencer

UART receive-frame controller for the apb_uart receive path. Detects the start-bit falling edge on the synchronized serial input and paces bit sampling with the 16x baud enable. Sequences start, data, optional parity and stop bits, then delivers one assembled character with parity, framing and break status. Sits between the RX input synchronizer/filter and the receive FIFO/line-status logic.

## Interface
- No parameters. Word length and parity are run-time inputs.
- CLK  in  1  system clock; all logic on rising edge
- RST  in  1  reset, synchronous, active-low: all state is reset when RST = 0 at a rising CLK edge
- RXCLK  in  1  16x baud enable, single-cycle pulse
- CLEAR  in  1  synchronous abort; returns to IDLE and clears outputs (RST has priority)
- RXD  in  1  serial input, already synchronized; idle level 1
- WLS  in  2  word length: 00=5, 01=6, 10=7, 11=8 data bits
- PEN  in  1  parity enable
- EPS  in  1  even parity select
- SP  in  1  stick parity
- DOUT  out  8  received character, LSB-aligned; unused upper bits 0
- PE  out  1  parity error of the last character
- FE  out  1  framing error (stop bit sampled 0)
- BI  out  1  break: data, parity (if enabled) and stop all sampled 0
- RXFINISHED  out  1  one-cycle pulse when DOUT/PE/FE/BI update
- BUSY  out  1  1 whenever the state is not IDLE

## Operation
- Reset and CLEAR values: state IDLE, DOUT=0, PE=FE=BI=0, RXFINISHED=0, BUSY=0. The internal RXD delay register resets to 1.
- Falling edge: the delayed-RXD register is 1 and RXD is 0, evaluated combinationally each cycle, independent of RXCLK.
- Tick counter: 4 bits, +1 on each RXCLK, wraps 15->0. Sample event is RXCLK=1 with counter=7.
- States: IDLE, START, DATA, PAR, STOP.
- IDLE: on a falling edge, clear the counter and go to START. In the same cycle, latch WLS/PEN/EPS/SP as the frame configuration and clear the shift register and bit count. An RXCLK in this cycle is not counted.
- START: at the sample event, RXD=1 is a false start: go to IDLE with no RXFINISHED. RXD=0 goes to DATA.
- DATA: at each sample event, shift RXD in LSB-first. After the (5+WLS)-th bit, go to PAR if PEN, else STOP.
- PAR: at the sample event, store the parity bit, then go to STOP.
- STOP: at the sample event, go to IDLE and perform the update below in the same cycle.
  - FE = ~RXD.
  - PE (only when PEN=1, else 0) = received parity != expected parity.
    - SP=0, EPS=1: expected = XOR(data).
    - SP=0, EPS=0: expected = ~XOR(data).
    - SP=1: expected = ~EPS.
  - BI = data==0, and parity bit==0 when enabled, and RXD==0.
  - DOUT = data, right-aligned.
  - RXFINISHED pulses for exactly that one cycle.
- Only one stop bit is checked, regardless of the transmit stop-bit setting.
- Re-arm: a new frame needs a fresh falling edge. During a sustained break the block stays in IDLE after reporting once.
- Changing configuration inputs mid-frame has no effect on the current frame.
- DOUT/PE/FE/BI hold their values until the next RXFINISHED or a reset/CLEAR.

## Timing
- Falling edge seen in cycle n -> state=START and BUSY=1 in cycle n+1.
- Each sample occurs 8 RXCLK ticks after the bit's leading edge (mid-bit). Bit k is sampled at tick 16k+8 after the start edge; the first tick counted is the first RXCLK after the edge cycle.
- 8N1 frame: RXFINISHED at tick 152 after the edge. Each added bit (parity) adds 16 ticks; each removed data bit subtracts 16.
- Outputs are registered and change in the cycle after the STOP sample event. RXFINISHED is high for that single cycle. BUSY=0 from the same cycle.
- RST=0 or CLEAR=1 mid-frame: next cycle in IDLE with all outputs at reset values and no RXFINISHED. A subsequent frame requires a new falling edge.
- A falling edge in the same cycle as the STOP update is ignored (state not yet IDLE).

## Test plan
- 8N1, RXCLK every 4 CLK, byte 0xA5 -> one RXFINISHED; DOUT=0xA5, PE=FE=BI=0; BUSY low afterward.
- 7E1 (WLS=10, PEN=1, EPS=1), data 0x35 sent with parity 1 (correct is 0) -> DOUT=0x35, PE=1, FE=0.
- RXD low for 3 RXCLK ticks, then high -> no RXFINISHED; BUSY returns to 0 after the tick-8 sample.
- Break: RXD held 0 for 30 bit times, 5N1 -> exactly one RXFINISHED with DOUT=0x00, FE=1, BI=1. No further pulses until RXD goes 1 then 0.
- Stick parity SP=1, EPS=1, 8 bits, 0xFF with parity bit 0 -> PE=0; same frame with parity bit 1 -> PE=1.
- Assert RST=0, then separately CLEAR=1, during the DATA state -> next cycle BUSY=0, DOUT=0, flags=0, no RXFINISHED. A following clean 0x3C frame is received correctly.
